// File: rtl/pad_line_mux_sync.sv
// Pad-line multiplexer for one chip edge: routes one of N_MACROS macros onto the pads with
// registered outputs, a high-Z guard window on every ownership change, and a synchronised input path.
module pad_line_mux_sync #(
  parameter int N_MACROS     = 4,
  parameter int WIDTH        = 10,
  parameter int GUARD_CYCLES = 2,
  parameter int SYNC_STAGES  = 2,
  localparam int SELW        = $clog2(N_MACROS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SELW-1:0]           cfg_i,
  input  logic                      cfg_valid_i,
  input  logic [N_MACROS*WIDTH-1:0] macro_o,
  input  logic [N_MACROS*WIDTH-1:0] macro_oe,
  output logic [WIDTH-1:0]          pad_o,
  output logic [WIDTH-1:0]          pad_oe,
  input  logic [WIDTH-1:0]          pad_i,
  output logic [N_MACROS*WIDTH-1:0] macro_i,
  output logic [SELW-1:0]           cur_cfg,
  output logic                      switching,
  output logic                      cfg_err
);

  // One spare bit so the handover threshold of 2 is representable even for a 1-cycle guard.
  localparam int CNTW = $clog2(GUARD_CYCLES + 1) + 1;
  localparam logic [CNTW-1:0] GUARD_LOAD = CNTW'(GUARD_CYCLES);
  localparam logic [SELW:0]   NUM_SEL    = (SELW + 1)'(N_MACROS);

  typedef enum logic {
    ACTIVE,
    GUARD
  } state_t;

  state_t            state, state_next;
  logic [CNTW-1:0]   count, count_next;
  logic [SELW-1:0]   pending, pending_next;
  logic [SELW-1:0]   cur_next;
  logic [WIDTH-1:0]  pad_o_next, pad_oe_next;
  logic              err_next;
  logic [WIDTH-1:0]  sel_o, sel_oe;
  logic              idx_ok;
  logic [WIDTH-1:0]  sync_out;

  assign idx_ok    = ({1'b0, cfg_i} < NUM_SEL);
  assign switching = (state == GUARD);

  // Data and enable are always taken from the same macro slice.
  always_comb begin
    sel_o  = '0;
    sel_oe = '0;
    for (int k = 0; k < N_MACROS; k++) begin
      if (cur_cfg == SELW'(k)) begin
        sel_o  = macro_o[k*WIDTH +: WIDTH];
        sel_oe = macro_oe[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    pending_next = pending;
    cur_next     = cur_cfg;
    pad_o_next   = '0;
    pad_oe_next  = '0;
    err_next     = 1'b0;
    case (state)
      ACTIVE: begin
        pad_o_next  = sel_o;
        pad_oe_next = sel_oe;
        if (cfg_valid_i) begin
          if (!idx_ok) begin
            err_next = 1'b1;
          end else if (cfg_i != cur_cfg) begin
            pending_next = cfg_i;
            count_next   = GUARD_LOAD;
            state_next   = GUARD;
            pad_o_next   = '0;
            pad_oe_next  = '0;
          end
        end
      end
      GUARD: begin
        // Handover happens on the edge where the counter steps down to 1, so the pads
        // stay disabled for exactly GUARD_CYCLES cycles counted from the acceptance edge.
        if (count > CNTW'(1)) begin
          count_next = count - CNTW'(1);
        end
        if (count <= CNTW'(2)) begin
          cur_next   = pending;
          state_next = ACTIVE;
        end
      end
      default: begin
        state_next = GUARD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= GUARD;
      count   <= GUARD_LOAD;
      pending <= '0;
      cur_cfg <= '0;
      pad_o   <= '0;
      pad_oe  <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pending <= pending_next;
      cur_cfg <= cur_next;
      pad_o   <= pad_o_next;
      pad_oe  <= pad_oe_next;
      cfg_err <= err_next;
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_out = pad_i;
    end else begin : g_sync
      logic [WIDTH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
          end
        end else begin
          sync_q[0] <= pad_i;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
          end
        end
      end
      assign sync_out = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Every macro sees the same input copy regardless of which one owns the outputs.
  assign macro_i = {N_MACROS{sync_out}};

endmodule

// File: tb/tb_pad_line_mux_sync.sv
// Scoreboard bench for pad_line_mux_sync: two instances (3 macros/2-stage sync/2-cycle guard and
// 4 macros/no sync/3-cycle guard) share stimulus and are checked against a cycle reference model.
module tb_pad_line_mux_sync;

  typedef struct {
    logic [9:0] pad_o;
    logic [9:0] pad_oe;
    logic [1:0] cur;
    logic       sw;
    logic       err;
    logic [9:0] mi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [1:0]  cfg;
  logic [39:0] mo, moe;
  logic [9:0]  pad_in;

  logic [9:0]  a_pad_o, a_pad_oe, b_pad_o, b_pad_oe;
  logic [29:0] a_macro_i;
  logic [39:0] b_macro_i;
  logic [1:0]  a_cur, b_cur;
  logic        a_sw, a_err, b_sw, b_err;

  exp_t exp_q [2][$];
  int   check_count = 0;
  int   pass_count  = 0;

  // Reference model state, per instance.
  int   p_n [2] = '{3, 4};
  int   p_g [2] = '{2, 3};
  int   p_s [2] = '{2, 0};
  bit   m_sw [2];
  int   m_left [2];
  int   m_owner [2];
  int   m_pend [2];
  logic [9:0] m_pad [2];
  logic [9:0] m_oe [2];
  bit   m_err [2];
  logic [9:0] pad_hist [$];

  always #5 clk = ~clk;

  pad_line_mux_sync #(.N_MACROS(3), .WIDTH(10), .GUARD_CYCLES(2), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_i(cfg), .cfg_valid_i(cfg_valid),
    .macro_o(mo[29:0]), .macro_oe(moe[29:0]), .pad_o(a_pad_o), .pad_oe(a_pad_oe),
    .pad_i(pad_in), .macro_i(a_macro_i), .cur_cfg(a_cur), .switching(a_sw), .cfg_err(a_err)
  );

  pad_line_mux_sync #(.N_MACROS(4), .WIDTH(10), .GUARD_CYCLES(3), .SYNC_STAGES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_i(cfg), .cfg_valid_i(cfg_valid),
    .macro_o(mo), .macro_oe(moe), .pad_o(b_pad_o), .pad_oe(b_pad_oe),
    .pad_i(pad_in), .macro_i(b_macro_i), .cur_cfg(b_cur), .switching(b_sw), .cfg_err(b_err)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_sw[d]    = 1'b1;
      m_left[d]  = (p_g[d] > 1) ? p_g[d] - 1 : 1;
      m_owner[d] = 0;
      m_pend[d]  = 0;
      m_pad[d]   = '0;
      m_oe[d]    = '0;
      m_err[d]   = 1'b0;
    end
    pad_hist.delete();
  endtask

  // One clock edge of the line: owner drives unless a handover is in progress.
  task automatic model_step(input logic v, input logic [1:0] c, input logic [39:0] o,
                            input logic [39:0] oe, input logic [9:0] p);
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      if (!m_sw[d]) begin
        m_pad[d] = o[m_owner[d]*10 +: 10];
        m_oe[d]  = oe[m_owner[d]*10 +: 10];
        if (v) begin
          if (int'(c) >= p_n[d]) begin
            m_err[d] = 1'b1;
          end else if (int'(c) != m_owner[d]) begin
            m_pend[d] = int'(c);
            m_sw[d]   = 1'b1;
            m_left[d] = (p_g[d] > 1) ? p_g[d] - 1 : 1;
            m_pad[d]  = '0;
            m_oe[d]   = '0;
          end
        end
      end else begin
        m_pad[d]  = '0;
        m_oe[d]   = '0;
        m_left[d] = m_left[d] - 1;
        if (m_left[d] == 0) begin
          m_sw[d]    = 1'b0;
          m_owner[d] = m_pend[d];
        end
      end
    end
    pad_hist.push_back(p);
  endtask

  task automatic apply_stimulus(input logic nrst, input logic v, input logic [1:0] c,
                                input logic [39:0] o, input logic [39:0] oe, input logic [9:0] p);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) model_step(cfg_valid, cfg, mo, moe, pad_in);
    rst_n = nrst; cfg_valid = v; cfg = c; mo = o; moe = oe; pad_in = p;
    if (!nrst) model_reset();
    for (int d = 0; d < 2; d++) begin
      e.pad_o = m_pad[d];
      e.pad_oe = m_oe[d];
      e.cur = 2'(m_owner[d]);
      e.sw = m_sw[d];
      e.err = m_err[d];
      if (p_s[d] == 0) e.mi = nrst ? p : pad_in;
      else if (pad_hist.size() >= p_s[d]) e.mi = pad_hist[pad_hist.size() - p_s[d]];
      else e.mi = '0;
      exp_q[d].push_back(e);
    end
  endtask

  task automatic check_dut(input int d, input exp_t e, input logic [9:0] po, input logic [9:0] poe,
                           input logic [1:0] cur, input logic sw, input logic err,
                           input logic [39:0] mi);
    string n;
    n = (d == 0) ? "a" : "b";
    check_output({n, ".pad_o"}, 64'(po), 64'(e.pad_o));
    check_output({n, ".pad_oe"}, 64'(poe), 64'(e.pad_oe));
    check_output({n, ".cur_cfg"}, 64'(cur), 64'(e.cur));
    check_output({n, ".switching"}, 64'(sw), 64'(e.sw));
    check_output({n, ".cfg_err"}, 64'(err), 64'(e.err));
    for (int k = 0; k < p_n[d]; k++)
      check_output($sformatf("%s.macro_i[%0d]", n, k), 64'(mi[k*10 +: 10]), 64'(e.mi));
  endtask

  // Monitor: outputs are presented every cycle, so one expectation per instance per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q[0].size() > 0) begin
        e = exp_q[0].pop_front();
        check_dut(0, e, a_pad_o, a_pad_oe, a_cur, a_sw, a_err, {10'b0, a_macro_i});
      end
      if (exp_q[1].size() > 0) begin
        e = exp_q[1].pop_front();
        check_dut(1, e, b_pad_o, b_pad_oe, b_cur, b_sw, b_err, b_macro_i);
      end
    end
  end

  initial begin
    logic [39:0] ro, roe, dir_o, all_oe;
    logic [63:0] r;
    logic [9:0]  rp;
    dir_o  = {10'h0, 10'h2AA, 10'h0, 10'h155};
    all_oe = {4{10'h3FF}};
    rst_n = 1'b0; cfg_valid = 1'b0; cfg = '0; mo = '0; moe = '0; pad_in = '0;
    model_reset();

    repeat (3) apply_stimulus(1'b0, 1'b0, 2'd0, dir_o, all_oe, 10'h0);
    repeat (4) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h0);
    apply_stimulus(1'b1, 1'b1, 2'd2, dir_o, all_oe, 10'h0);
    repeat (5) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h0);
    apply_stimulus(1'b1, 1'b1, 2'd2, dir_o, all_oe, 10'h0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h0);
    apply_stimulus(1'b1, 1'b1, 2'd3, dir_o, all_oe, 10'h0);
    repeat (5) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h0);
    apply_stimulus(1'b1, 1'b1, 2'd1, dir_o, all_oe, 10'h0);
    apply_stimulus(1'b1, 1'b1, 2'd3, dir_o, all_oe, 10'h0);
    repeat (6) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h0);
    repeat (4) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h3FF);
    apply_stimulus(1'b1, 1'b1, 2'd0, dir_o, all_oe, 10'h3FF);
    repeat (2) apply_stimulus(1'b0, 1'b0, 2'd0, dir_o, all_oe, 10'h3FF);
    repeat (4) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h155);

    for (int i = 0; i < 400; i++) begin
      r   = {$urandom(), $urandom()};
      ro  = r[39:0];
      r   = {$urandom(), $urandom()};
      roe = r[39:0];
      rp  = 10'($urandom());
      apply_stimulus(($urandom_range(99) != 0), ($urandom_range(3) == 0),
                     2'($urandom_range(3)), ro, roe, rp);
    end
    repeat (4) apply_stimulus(1'b1, 1'b0, 2'd0, dir_o, all_oe, 10'h0);

    for (int i = 0; i < 10 && (exp_q[0].size() > 0 || exp_q[1].size() > 0); i++) @(negedge clk);
    #1;
    if (exp_q[0].size() > 0 || exp_q[1].size() > 0) begin
      check_count++;
      $display("[TB] FAIL drain: %0d expectations left, required 0",
               exp_q[0].size() + exp_q[1].size());
    end
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
